braille_quiz_ctrl: RTL and testbench

Sequencing controller for the Braille trainer's quiz mode. It picks a pseudo-random target letter and presents it for display. It then waits for the learner to load a six-dot switch pattern through the existing button-shaper, load and switch-to-alphabet path. It grades each attempt, keeps score over a fixed number of rounds, and drives the seven-segment display enable.

---
 rtl/braille_quiz_ctrl.sv | 160 ++++++++++++++++
 tb/tb_braille_quiz_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/braille_quiz_ctrl.sv
// Quiz-mode sequencer for the Braille trainer: picks LFSR targets, grades loaded answers, keeps score.
// Define QUIZ_TIMEOUT_EN to add a per-round response window that grades a silent learner as wrong.
module braille_quiz_ctrl #(
    parameter int         ROUNDS         = 10,
    parameter int         FB_CYCLES      = 25_000_000,
    parameter int         TIMEOUT_CYCLES = 250_000_000,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start_Pulse,
    input  logic       Load_Pulse,
    input  logic [3:0] Sw_Alphabet,
    output logic [3:0] Target,
    output logic       Disp_Enable,
    output logic       Result_Valid,
    output logic       Correct,
    output logic [3:0] Score,
    output logic [3:0] Round,
    output logic       Done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PICK  = 3'd1;
    localparam logic [2:0] S_SHOW  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_FB    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int         FBW      = (FB_CYCLES > 1) ? $clog2(FB_CYCLES) : 1;
    localparam logic [3:0] ROUNDS_L = 4'(ROUNDS);

    if (ROUNDS < 1 || ROUNDS > 15 || FB_CYCLES < 1 || TIMEOUT_CYCLES < 1 || LFSR_SEED == 8'h00)
    begin : g_bad_param
        $error("braille_quiz_ctrl: illegal parameter value");
    end

    logic [2:0]     state_q, state_d;
    logic [7:0]     lfsr_q, lfsr_d;
    logic [3:0]     target_q, target_d;
    logic [3:0]     ans_q, ans_d;
    logic           ans_ok_q, ans_ok_d;
    logic           correct_q, correct_d;
    logic [3:0]     score_q, score_d;
    logic [3:0]     round_q, round_d;
    logic [FBW-1:0] fb_cnt_q, fb_cnt_d;
    logic [3:0]     cand_raw, cand;

`ifdef QUIZ_TIMEOUT_EN
    localparam int TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
`endif

    // Fold 10..15 down onto 4..9, then step past the previous target so rounds never repeat.
    always_comb begin
        cand_raw = (lfsr_q[3:0] > 4'd9) ? lfsr_q[3:0] - 4'd6 : lfsr_q[3:0];
        cand     = cand_raw;
        if (cand_raw == target_q)
            cand = (cand_raw == 4'd9) ? 4'd0 : cand_raw + 4'd1;
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        target_d  = target_q;
        ans_d     = ans_q;
        ans_ok_d  = ans_ok_q;
        correct_d = correct_q;
        score_d   = score_q;
        round_d   = round_q;
        fb_cnt_d  = fb_cnt_q;
`ifdef QUIZ_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start_Pulse) begin
                    state_d = S_PICK;
                    score_d = 4'd0;
                    round_d = 4'd0;
                end
            end
            S_PICK: begin
                target_d = cand;
                state_d  = S_SHOW;
`ifdef QUIZ_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            S_SHOW: begin
                if (Load_Pulse) begin
                    ans_d    = Sw_Alphabet;
                    ans_ok_d = 1'b1;
                    state_d  = S_CHECK;
                end
`ifdef QUIZ_TIMEOUT_EN
                else if (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
                    ans_ok_d = 1'b0;
                    state_d  = S_CHECK;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_CHECK: begin
                correct_d = ans_ok_q && (ans_q <= 4'd9) && (ans_q == target_q);
                score_d   = score_q + 4'(correct_d);
                round_d   = round_q + 4'd1;
                fb_cnt_d  = '0;
                state_d   = S_FB;
            end
            S_FB: begin
                if (fb_cnt_q == FBW'(FB_CYCLES - 1))
                    state_d = (round_q < ROUNDS_L) ? S_PICK : S_DONE;
                else
                    fb_cnt_d = fb_cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= LFSR_SEED;
            target_q  <= 4'd0;
            ans_q     <= 4'd0;
            ans_ok_q  <= 1'b0;
            correct_q <= 1'b0;
            score_q   <= 4'd0;
            round_q   <= 4'd0;
            fb_cnt_q  <= '0;
`ifdef QUIZ_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            target_q  <= target_d;
            ans_q     <= ans_d;
            ans_ok_q  <= ans_ok_d;
            correct_q <= correct_d;
            score_q   <= score_d;
            round_q   <= round_d;
            fb_cnt_q  <= fb_cnt_d;
`ifdef QUIZ_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    assign Target       = target_q;
    assign Disp_Enable  = (state_q == S_SHOW) || (state_q == S_FB);
    assign Result_Valid = (state_q == S_FB);
    assign Correct      = correct_q;
    assign Score        = score_q;
    assign Round        = round_q;
    assign Done         = (state_q == S_DONE);

endmodule

// File: tb/tb_braille_quiz_ctrl.sv
// Table-driven bench for braille_quiz_ctrl with ROUNDS=3, FB_CYCLES=4, TIMEOUT_CYCLES=20, seed 8'h01.
module tb_braille_quiz_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Start_Pulse, Load_Pulse;
    logic [3:0] Sw_Alphabet;
    logic [3:0] Target, Score, Round;
    logic       Disp_Enable, Result_Valid, Correct, Done;

    braille_quiz_ctrl #(
        .ROUNDS(3), .FB_CYCLES(4), .TIMEOUT_CYCLES(20), .LFSR_SEED(8'h01)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Start_Pulse(Start_Pulse), .Load_Pulse(Load_Pulse),
        .Sw_Alphabet(Sw_Alphabet), .Target(Target), .Disp_Enable(Disp_Enable),
        .Result_Valid(Result_Valid), .Correct(Correct), .Score(Score), .Round(Round),
        .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Reference LFSR; m_prev holds the value the DUT saw at the most recent edge.
    logic [7:0] m_l, m_prev;
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_l    <= 8'h01;
            m_prev <= 8'h01;
        end else begin
            m_prev <= m_l;
            m_l    <= {m_l[6:0], m_l[7] ^ m_l[5] ^ m_l[4] ^ m_l[3]};
        end
    end

    typedef struct {
        bit         start, load, use_tgt, pick;
        logic [3:0] sw;
        bit         disp, rv, cor;
        logic [3:0] score, round;
        bit         done;
    } vec_t;

    vec_t       vecs[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_tgt  = 4'd0;
    logic [3:0] last_tgt = 4'd0;

    function automatic logic [3:0] cand(input logic [7:0] l, input logic [3:0] prev);
        logic [3:0] c;
        c = l[3:0];
        if (c > 4'd9) c = c - 4'd6;
        if (c == prev) c = (c == 4'd9) ? 4'd0 : c + 4'd1;
        return c;
    endfunction

    task automatic chk(input string name, input int row, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0d want=%0d", name, row, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic r(input bit start, input bit load, input bit use_tgt, input logic [3:0] sw,
                     input bit pick, input bit disp, input bit rv, input bit cor,
                     input int score, input int round, input bit done);
        vec_t v;
        v.start = start; v.load = load; v.use_tgt = use_tgt; v.sw = sw; v.pick = pick;
        v.disp = disp; v.rv = rv; v.cor = cor;
        v.score = 4'(score); v.round = 4'(round); v.done = done;
        vecs.push_back(v);
    endtask

    // Start pulse: PICK after one edge, SHOW (target latched) after the next.
    task automatic add_start();
        r(1, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        r(0, 0, 0, 4'd0, 1, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic add_show(input int n, input bit start, input int sc, input int rd);
        for (int i = 0; i < n; i++) r(start, 0, 0, 4'd0, 0, 1, 0, 0, sc, rd, 0);
    endtask

    task automatic add_round(input bit ok, input int sc, input int rd, input bit last, input bit start_fb);
        r(0, 1, ok, ok ? 4'd0 : 4'hC, 0, 0, 0, 0, sc, rd, 0);
        for (int i = 0; i < 4; i++)
            r(start_fb && i == 1, 0, 0, 4'd0, 0, 1, 1, ok, sc + int'(ok), rd + 1, 0);
        if (last) begin
            r(0, 0, 0, 4'd0, 0, 0, 0, 0, sc + int'(ok), rd + 1, 1);
        end else begin
            r(0, 0, 0, 4'd0, 0, 0, 0, 0, sc + int'(ok), rd + 1, 0);
            r(0, 0, 0, 4'd0, 1, 1, 0, 0, sc + int'(ok), rd + 1, 0);
        end
    endtask

    initial begin
        // Idle after reset, including an ignored load strobe.
        for (int i = 0; i < 10; i++) r(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        r(0, 1, 0, 4'd3, 0, 0, 0, 0, 0, 0, 0);
        // Quiz A: three correct answers, then a load in DONE is ignored.
        add_start();
        add_round(1, 0, 0, 0, 0);
        add_round(1, 1, 1, 0, 0);
        add_round(1, 2, 2, 1, 0);
        r(0, 1, 0, 4'd2, 0, 0, 0, 0, 3, 3, 1);
        // Quiz B: restart from DONE, stray starts in SHOW/FEEDBACK, invalid first answer.
        add_start();
        add_show(1, 1, 0, 0);
        add_round(0, 0, 0, 0, 1);
        add_round(1, 0, 1, 0, 0);
        add_round(1, 1, 2, 1, 0);
`ifdef QUIZ_TIMEOUT_EN
        // Quiz C: silent round times out; next round answered on the expiry cycle.
        add_start();
        add_show(19, 0, 0, 0);
        r(0, 0, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) r(0, 0, 0, 4'd0, 0, 1, 1, 0, 0, 1, 0);
        r(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 1, 0);
        r(0, 0, 0, 4'd0, 1, 1, 0, 0, 0, 1, 0);
        add_show(19, 0, 0, 1);
        add_round(1, 0, 1, 0, 0);
        add_round(1, 1, 2, 1, 0);
`else
        // Quiz C: without the timeout, SHOW waits indefinitely.
        add_start();
        add_show(25, 0, 0, 0);
        add_round(1, 0, 0, 0, 0);
        add_round(1, 1, 1, 0, 0);
        add_round(1, 2, 2, 1, 0);
`endif
        // Quiz D: one correct round, leaving the DUT in SHOW of round 2.
        add_start();
        add_round(1, 0, 0, 0, 0);

        Rst = 1'b0; Start_Pulse = 1'b0; Load_Pulse = 1'b0; Sw_Alphabet = 4'd0;
        #2;
        chk("rst_target", -1, Target, 0);
        chk("rst_disp", -1, Disp_Enable, 0);
        chk("rst_rv", -1, Result_Valid, 0);
        chk("rst_correct", -1, Correct, 0);
        chk("rst_score", -1, Score, 0);
        chk("rst_round", -1, Round, 0);
        chk("rst_done", -1, Done, 0);
        tick(); tick();
        Rst = 1'b1;

        foreach (vecs[i]) begin
            Start_Pulse = vecs[i].start;
            Load_Pulse  = vecs[i].load;
            Sw_Alphabet = vecs[i].use_tgt ? exp_tgt : vecs[i].sw;
            tick();
            Start_Pulse = 1'b0;
            Load_Pulse  = 1'b0;
            if (vecs[i].pick) begin
                exp_tgt = cand(m_prev, exp_tgt);
                chk("tgt_repeat", i, int'(Target != last_tgt), 1);
                last_tgt = Target;
            end
            chk("target", i, Target, exp_tgt);
            chk("disp", i, Disp_Enable, vecs[i].disp);
            chk("rv", i, Result_Valid, vecs[i].rv);
            if (vecs[i].rv) chk("correct", i, Correct, vecs[i].cor);
            chk("score", i, Score, vecs[i].score);
            chk("round", i, Round, vecs[i].round);
            chk("done", i, Done, vecs[i].done);
        end

        // Correct answer for round 2, then reset in the middle of its FEEDBACK.
        Load_Pulse  = 1'b1;
        Sw_Alphabet = exp_tgt;
        tick();
        Load_Pulse = 1'b0;
        tick();
        chk("mid_rv", -2, Result_Valid, 1);
        chk("mid_round", -2, Round, 2);
        chk("mid_score", -2, Score, 2);
        #2;
        Rst = 1'b0;
        #1;
        chk("async_target", -3, Target, 0);
        chk("async_disp", -3, Disp_Enable, 0);
        chk("async_rv", -3, Result_Valid, 0);
        chk("async_correct", -3, Correct, 0);
        chk("async_score", -3, Score, 0);
        chk("async_round", -3, Round, 0);
        chk("async_done", -3, Done, 0);
        @(negedge Clk);
        Rst = 1'b1;
        exp_tgt = 4'd0;
        tick(); tick();
        chk("post_idle_disp", -4, Disp_Enable, 0);
        chk("post_idle_done", -4, Done, 0);
        Start_Pulse = 1'b1;
        tick();
        Start_Pulse = 1'b0;
        chk("post_pick_disp", -5, Disp_Enable, 0);
        tick();
        exp_tgt = cand(m_prev, exp_tgt);
        chk("post_show_disp", -6, Disp_Enable, 1);
        chk("post_show_target", -6, Target, exp_tgt);
        chk("post_show_round", -6, Round, 0);
        chk("post_show_score", -6, Score, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
